imm_field_encoder: RTL and testbench

- Inverse of the ID-stage immediate sign-extension path. Takes a full-width signed immediate plus a format code and scatters its bits into the immediate fields of a 32-bit RISC-V instruction word.
- Checks that the value is representable in the chosen format, i.e. sign-extension in ID reproduces it exactly.
- Sits in the instruction-memory loader / directed-stimulus path ahead of fetch.
- Valid/ready on both sides, one-cycle latency, full throughput via a skid buffer.

---
 rtl/imm_pkg.sv | 92 +++++++++
 rtl/imm_skid_buffer.sv | 56 +++++
 rtl/imm_field_encoder.sv | 83 ++++++++
 tb/tb_imm_field_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types, constants and encode/check helpers for the RISC-V immediate field encoder.
package imm_pkg;

  localparam int unsigned IMM_W   = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FMT_W   = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4
  } imm_fmt_e;

  // Highest bit position that still carries magnitude; everything above it must be sign copies.
  localparam int unsigned RANGE_N_I = 11;
  localparam int unsigned RANGE_N_S = 11;
  localparam int unsigned RANGE_N_B = 12;
  localparam int unsigned RANGE_N_J = 20;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               range_err;
    logic               align_err;
  } imm_payload_t;

  // Scatter immediate bits into the instruction fields; reserved formats pass base through.
  function automatic logic [INSTR_W-1:0] imm_scatter(input logic [FMT_W-1:0]   fmt,
                                                     input logic [IMM_W-1:0]   imm,
                                                     input logic [INSTR_W-1:0] base);
    logic [INSTR_W-1:0] w;
    w = base;
    case (fmt)
      FMT_I: w[31:20] = imm[11:0];
      FMT_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      FMT_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      FMT_U: w[31:12] = imm[31:12];
      FMT_J: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      default: w = base;
    endcase
    return w;
  endfunction

  // True when imm[31:n] are all identical, i.e. sign extension from bit n reproduces imm.
  function automatic logic imm_fits(input logic [IMM_W-1:0] imm, input int unsigned n);
    logic [IMM_W-1:0] hi;
    hi = IMM_W'($signed(imm) >>> n);
    return (hi == '0) || (hi == '1);
  endfunction

  // Representability check; reserved formats always flag.
  function automatic logic imm_range_err(input logic [FMT_W-1:0] fmt,
                                         input logic [IMM_W-1:0] imm);
    logic err;
    case (fmt)
      FMT_I:   err = !imm_fits(imm, RANGE_N_I);
      FMT_S:   err = !imm_fits(imm, RANGE_N_S);
      FMT_B:   err = !imm_fits(imm, RANGE_N_B);
      FMT_U:   err = 1'b0;
      FMT_J:   err = !imm_fits(imm, RANGE_N_J);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Low bits that the format drops must be zero.
  function automatic logic imm_align_err(input logic [FMT_W-1:0] fmt,
                                         input logic [IMM_W-1:0] imm);
    logic err;
    case (fmt)
      FMT_B, FMT_J: err = imm[0];
      FMT_U:        err = (imm[11:0] != 12'h000);
      default:      err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/imm_skid_buffer.sv
// Two-entry valid/ready register slice: output register plus one skid entry, FIFO order.
module imm_skid_buffer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_in_ready;
  logic             w_push;
  logic             w_pop;

  assign w_push    = in_valid && r_in_ready;
  assign w_pop     = r_out_valid && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Output register refills from skid first, else from the input; stalled accepts park in skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b1;
    end else if (!r_out_valid || w_pop) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else begin
        r_out_valid <= w_push;
        if (w_push) begin
          r_out_data <= in_data;
        end
      end
    end else if (w_push) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
      r_in_ready   <= 1'b0;
    end
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Encodes a signed immediate into the fields of a RISC-V instruction word, with range/align flags.
module imm_field_encoder
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_fmt,
  input  logic [DATA_WIDTH-1:0]  in_value,
  input  logic [INSTR_WIDTH-1:0] in_base,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   out_range_err,
  output logic                   out_align_err,
  input  logic                   cnt_clr,
  output logic [CNT_WIDTH-1:0]   cnt_encoded,
  output logic [CNT_WIDTH-1:0]   cnt_errors
);

  imm_payload_t                     w_in_payload;
  imm_payload_t                     w_out_payload;
  logic [$bits(imm_payload_t)-1:0]  w_out_data;
  logic [IMM_W-1:0]                 w_imm;
  logic                             w_out_valid;
  logic                             w_done;
  logic [CNT_WIDTH-1:0]             r_cnt_encoded;
  logic [CNT_WIDTH-1:0]             r_cnt_errors;

  // Combinational scatter and checks; errors never block the encode.
  always_comb begin
    w_imm                  = IMM_W'(in_value);
    w_in_payload.instr     = imm_scatter(in_fmt, w_imm, INSTR_W'(in_base));
    w_in_payload.range_err = imm_range_err(in_fmt, w_imm);
    w_in_payload.align_err = imm_align_err(in_fmt, w_imm);
  end

  imm_skid_buffer #(
    .WIDTH($bits(imm_payload_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_payload),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data)
  );

  assign w_out_payload = imm_payload_t'(w_out_data);
  assign out_valid     = w_out_valid;
  assign out_instr     = INSTR_WIDTH'(w_out_payload.instr);
  assign out_range_err = w_out_payload.range_err;
  assign out_align_err = w_out_payload.align_err;
  assign w_done        = w_out_valid && out_ready;
  assign cnt_encoded   = r_cnt_encoded;
  assign cnt_errors    = r_cnt_errors;

  // Saturating statistics on completed output handshakes; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_encoded <= '0;
      r_cnt_errors  <= '0;
    end else if (cnt_clr) begin
      r_cnt_encoded <= '0;
      r_cnt_errors  <= '0;
    end else if (w_done) begin
      if (r_cnt_encoded != '1) begin
        r_cnt_encoded <= r_cnt_encoded + CNT_WIDTH'(1);
      end
      if ((w_out_payload.range_err || w_out_payload.align_err) && (r_cnt_errors != '1)) begin
        r_cnt_errors <= r_cnt_errors + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed bench for imm_field_encoder with hand-computed expected words.
module tb_imm_field_encoder;

  localparam logic [2:0] F_I = 3'd0;
  localparam logic [2:0] F_S = 3'd1;
  localparam logic [2:0] F_B = 3'd2;
  localparam logic [2:0] F_U = 3'd3;
  localparam logic [2:0] F_J = 3'd4;
  localparam logic [2:0] F_R = 3'd5;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_value;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_range_err;
  logic        out_align_err;
  logic        cnt_clr;
  logic [15:0] cnt_encoded;
  logic [15:0] cnt_errors;

  int checks   = 0;
  int failures = 0;

  imm_field_encoder #(
    .DATA_WIDTH  (32),
    .INSTR_WIDTH (32),
    .CNT_WIDTH   (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_fmt        (in_fmt),
    .in_value      (in_value),
    .in_base       (in_base),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_range_err (out_range_err),
    .out_align_err (out_align_err),
    .cnt_clr       (cnt_clr),
    .cnt_encoded   (cnt_encoded),
    .cnt_errors    (cnt_errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then drop in_valid.
  task automatic send(input logic [2:0] f, input logic [31:0] v, input logic [31:0] b);
    in_valid = 1'b1;
    in_fmt   = f;
    in_value = v;
    in_base  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] instr, input logic re, input logic ae);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk32({tag, "_instr"}, out_instr, instr);
    chk1({tag, "_range"}, out_range_err, re);
    chk1({tag, "_align"}, out_align_err, ae);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_fmt    = 3'd0;
    in_value  = 32'h0;
    in_base   = 32'h0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk32("rst_out_instr", out_instr, 32'h0);
    chk1("rst_range", out_range_err, 1'b0);
    chk1("rst_align", out_align_err, 1'b0);
    chk32("rst_cnt_enc", 32'(cnt_encoded), 32'h0);
    chk32("rst_cnt_err", 32'(cnt_errors), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;

    // Directed encodings, one at a time with out_ready high.
    send(F_I, 32'hFFFFF800, 32'h00000013);
    chk_out("i_neg2048", 32'h80000013, 1'b0, 1'b0);
    tick();
    chk1("i_drained", out_valid, 1'b0);
    chk32("i_cnt_enc", 32'(cnt_encoded), 32'd1);
    chk32("i_cnt_err", 32'(cnt_errors), 32'd0);

    send(F_I, 32'h00000800, 32'h00000013);
    chk_out("i_2048", 32'h80000013, 1'b1, 1'b0);
    tick();
    chk32("i2_cnt_enc", 32'(cnt_encoded), 32'd2);
    chk32("i2_cnt_err", 32'(cnt_errors), 32'd1);

    send(F_B, 32'h00000FFE, 32'h00000063);
    chk_out("b_ffe", 32'h7E000FE3, 1'b0, 1'b0);
    tick();
    send(F_B, 32'h00000003, 32'h00000063);
    chk_out("b_odd", 32'h00000163, 1'b0, 1'b1);
    tick();
    send(F_U, 32'h12345000, 32'h00000037);
    chk_out("u_ok", 32'h12345037, 1'b0, 1'b0);
    tick();
    send(F_U, 32'h12345001, 32'h00000037);
    chk_out("u_low", 32'h12345037, 1'b0, 1'b1);
    tick();
    send(F_J, 32'h00100000, 32'h0000006F);
    chk_out("j_big", 32'h8000006F, 1'b1, 1'b0);
    tick();
    send(F_J, 32'hFFFFF000, 32'h0000006F);
    chk_out("j_neg", 32'h800FF06F, 1'b0, 1'b0);
    tick();
    send(F_S, 32'hFFFFFFFF, 32'h00002023);
    chk_out("s_m1", 32'hFE002FA3, 1'b0, 1'b0);
    tick();
    send(F_R, 32'h00000000, 32'h12345678);
    chk_out("rsv", 32'h12345678, 1'b1, 1'b0);
    tick();
    send(F_I, 32'h00000000, 32'hFFF00013);
    chk_out("i_base_imm_ignored", 32'h00000013, 1'b0, 1'b0);
    tick();
    chk32("dir_cnt_enc", 32'(cnt_encoded), 32'd11);
    chk32("dir_cnt_err", 32'(cnt_errors), 32'd5);

    // Backpressure: three back-to-back requests against a stalled output.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk32("bp_clr", 32'(cnt_encoded), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_fmt    = F_I;
    in_base   = 32'h00000013;
    in_value  = 32'd1;
    tick();
    chk1("bp_a_valid", out_valid, 1'b1);
    chk1("bp_ready_after_a", in_ready, 1'b1);
    chk32("bp_a_instr", out_instr, 32'h00100013);
    in_value = 32'd2;
    tick();
    chk1("bp_ready_after_b", in_ready, 1'b0);
    chk32("bp_hold_a", out_instr, 32'h00100013);
    in_value = 32'd3;
    tick();
    chk1("bp_c_waits", in_ready, 1'b0);
    chk32("bp_hold_a2", out_instr, 32'h00100013);
    out_ready = 1'b1;
    tick();
    chk32("bp_b_instr", out_instr, 32'h00200013);
    chk1("bp_ready_rise", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk32("bp_c_instr", out_instr, 32'h00300013);
    chk1("bp_c_valid", out_valid, 1'b1);
    tick();
    chk1("bp_drained", out_valid, 1'b0);
    chk32("bp_cnt_enc", 32'(cnt_encoded), 32'd3);

    // Saturation: stream erroring requests past 16'hFFFF handshakes.
    cnt_clr = 1'b1;
    tick();
    cnt_clr  = 1'b0;
    in_valid = 1'b1;
    in_fmt   = F_I;
    in_value = 32'h00000800;
    in_base  = 32'h00000013;
    repeat (65536) tick();
    chk32("sat_enc_exact", 32'(cnt_encoded), 32'h0000FFFF);
    chk32("sat_err_exact", 32'(cnt_errors), 32'h0000FFFF);
    tick();
    chk32("sat_enc_hold", 32'(cnt_encoded), 32'h0000FFFF);
    chk32("sat_err_hold", 32'(cnt_errors), 32'h0000FFFF);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk32("clr_prio_enc", 32'(cnt_encoded), 32'd0);
    chk32("clr_prio_err", 32'(cnt_errors), 32'd0);
    in_valid = 1'b0;
    tick();
    chk32("post_clr_enc", 32'(cnt_encoded), 32'd1);
    tick();

    // Reset with the skid entry occupied.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_value  = 32'd1;
    tick();
    in_value = 32'd2;
    tick();
    in_valid = 1'b0;
    chk1("skid_full", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrst_valid", out_valid, 1'b0);
    chk1("midrst_ready", in_ready, 1'b1);
    chk32("midrst_instr", out_instr, 32'h0);
    chk32("midrst_cnt", 32'(cnt_encoded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk1("postrst_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    send(F_I, 32'hFFFFF800, 32'h00000013);
    chk_out("postrst", 32'h80000013, 1'b0, 1'b0);
    tick();
    chk32("postrst_cnt", 32'(cnt_encoded), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
